// File: rtl/post_mux_vote_counter.sv
// rtl/post_mux_vote_counter.sv - multi-channel PUF response counter with majority vote (option: PMVC_STABILITY_FLAG_EN)
module post_mux_vote_counter #(
    parameter int NUM_CH = 4,
    parameter int TRIALS = 100,
    parameter int CNT_W  = 7
`ifdef PMVC_STABILITY_FLAG_EN
    ,
    parameter int MARGIN = 10
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    enable,
    input  logic                    sample_valid,
    input  logic [NUM_CH-1:0]       response,
    input  logic                    ack,
    output logic                    busy,
    output logic                    finished,
    output logic [CNT_W-1:0]        trial_count,
    output logic [NUM_CH*CNT_W-1:0] out_counter,
    output logic [NUM_CH-1:0]       vote
`ifdef PMVC_STABILITY_FLAG_EN
    ,
    output logic [NUM_CH-1:0]       unstable
`endif
);

    generate
        if ((TRIALS < 1) || ((2 ** CNT_W) <= TRIALS)) begin : g_param_check
            $error("post_mux_vote_counter: need TRIALS >= 1 and 2**CNT_W > TRIALS");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_TRIAL = CNT_W'(TRIALS - 1);
    localparam logic [CNT_W:0]   TRIALS_W   = (CNT_W + 1)'(TRIALS);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt      [NUM_CH];
    logic [CNT_W-1:0] cnt_next [NUM_CH];
    logic [NUM_CH-1:0] vote_next;
    logic             launch;
    logic             accept;
    logic             last_sample;

    assign launch      = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign accept      = (state == ST_COUNT) && enable && sample_valid;
    assign last_sample = accept && (trial_count == LAST_TRIAL);

    // Vote compares 2*count against TRIALS in CNT_W+1 bits; a tie yields 0.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_next[i]  = cnt[i] + CNT_W'(response[i]);
            vote_next[i] = {cnt_next[i], 1'b0} > TRIALS_W;
        end
    end

`ifdef PMVC_STABILITY_FLAG_EN
    localparam logic [31:0] TRIALS32 = 32'(TRIALS);
    localparam logic [31:0] MARGIN2  = 32'(2 * MARGIN);

    logic [NUM_CH-1:0] unstable_next;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if ((32'(cnt_next[i]) << 1) >= TRIALS32) begin
                unstable_next[i] = ((32'(cnt_next[i]) << 1) - TRIALS32) <= MARGIN2;
            end else begin
                unstable_next[i] = (TRIALS32 - (32'(cnt_next[i]) << 1)) <= MARGIN2;
            end
        end
    end
`endif

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
            assign out_counter[g*CNT_W +: CNT_W] = cnt[g];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            finished    <= 1'b0;
            trial_count <= '0;
            vote        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
`ifdef PMVC_STABILITY_FLAG_EN
            unstable    <= '0;
`endif
        end else if (launch) begin
            // start wins over a simultaneous ack in DONE; vote is kept until the next result
            state       <= ST_COUNT;
            busy        <= 1'b1;
            finished    <= 1'b0;
            trial_count <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (accept) begin
            trial_count <= trial_count + CNT_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= cnt_next[i];
            end
            if (last_sample) begin
                state    <= ST_DONE;
                busy     <= 1'b0;
                finished <= 1'b1;
                vote     <= vote_next;
`ifdef PMVC_STABILITY_FLAG_EN
                unstable <= unstable_next;
`endif
            end
        end else if ((state == ST_DONE) && ack) begin
            state    <= ST_IDLE;
            finished <= 1'b0;
        end else if ((state != ST_IDLE) && (state != ST_COUNT) && (state != ST_DONE)) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            finished <= 1'b0;
        end
    end

endmodule

// File: tb/tb_post_mux_vote_counter.sv
// tb/tb_post_mux_vote_counter.sv - scoreboard bench for post_mux_vote_counter (TRIALS=5 and TRIALS=4 instances)
module tb_post_mux_vote_counter;

    localparam int MARGIN_TB = 1;

    logic       clk = 1'b0;
    logic       reset, start, enable, sample_valid, ack;
    logic [1:0] response;

    logic       busy5, fin5, busy4, fin4;
    logic [2:0] tc5, tc4;
    logic [5:0] oc5, oc4;
    logic [1:0] vote5, vote4;
    logic [1:0] un5, un4;

    always #5 clk = ~clk;

    post_mux_vote_counter #(.NUM_CH(2), .TRIALS(5), .CNT_W(3)
`ifdef PMVC_STABILITY_FLAG_EN
        , .MARGIN(MARGIN_TB)
`endif
    ) dut5 (
        .clk(clk), .reset(reset), .start(start), .enable(enable),
        .sample_valid(sample_valid), .response(response), .ack(ack),
        .busy(busy5), .finished(fin5), .trial_count(tc5),
        .out_counter(oc5), .vote(vote5)
`ifdef PMVC_STABILITY_FLAG_EN
        , .unstable(un5)
`endif
    );

    post_mux_vote_counter #(.NUM_CH(2), .TRIALS(4), .CNT_W(3)
`ifdef PMVC_STABILITY_FLAG_EN
        , .MARGIN(MARGIN_TB)
`endif
    ) dut4 (
        .clk(clk), .reset(reset), .start(start), .enable(enable),
        .sample_valid(sample_valid), .response(response), .ack(ack),
        .busy(busy4), .finished(fin4), .trial_count(tc4),
        .out_counter(oc4), .vote(vote4)
`ifdef PMVC_STABILITY_FLAG_EN
        , .unstable(un4)
`endif
    );

`ifndef PMVC_STABILITY_FLAG_EN
    assign un5 = 2'b00;
    assign un4 = 2'b00;
`endif

    typedef struct {
        int         c0;
        int         c1;
        logic [1:0] vt;
        logic [1:0] un;
    } res_t;

    res_t q5[$];
    res_t q4[$];

    int         ms [2];
    int         mtc[2];
    int         mc [2][2];
    logic [1:0] mv [2];
    logic [1:0] mu [2];
    logic       prev_fin[2];
    bit         mon_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a measurement is the list of accepted samples; results follow from sums.
    task automatic model_step(input int k);
        int   t;
        res_t r;
        t = (k == 0) ? 5 : 4;
        if (!reset) begin
            ms[k] = 0; mtc[k] = 0; mc[k][0] = 0; mc[k][1] = 0; mv[k] = 0; mu[k] = 0;
        end else if (start && ms[k] != 1) begin
            ms[k] = 1; mtc[k] = 0; mc[k][0] = 0; mc[k][1] = 0;
        end else if (ms[k] == 1 && enable && sample_valid) begin
            for (int ch = 0; ch < 2; ch++) mc[k][ch] += int'(response[ch]);
            mtc[k]++;
            if (mtc[k] == t) begin
                ms[k] = 2;
                for (int ch = 0; ch < 2; ch++) begin
                    int d;
                    d = 2 * mc[k][ch] - t;
                    if (d < 0) d = -d;
                    mv[k][ch] = (2 * mc[k][ch] > t);
                    mu[k][ch] = (d <= 2 * MARGIN_TB);
                end
                r.c0 = mc[k][0]; r.c1 = mc[k][1]; r.vt = mv[k]; r.un = mu[k];
                if (k == 0) q5.push_back(r);
                else q4.push_back(r);
            end
        end else if (ms[k] == 2 && ack) begin
            ms[k] = 0;
        end
    endtask

    task automatic mon(input int k, input logic busy, input logic fin, input logic [2:0] tc,
                       input logic [5:0] oc, input logic [1:0] vt, input logic [1:0] un);
        string p;
        res_t  r;
        bit    have;
        p = (k == 0) ? "t5" : "t4";
        chk({p, "_busy"}, 32'(busy), 32'(ms[k] == 1));
        chk({p, "_finished"}, 32'(fin), 32'(ms[k] == 2));
        chk({p, "_trial_count"}, 32'(tc), 32'(mtc[k]));
        chk({p, "_out_counter"}, 32'(oc), 32'({3'(mc[k][1]), 3'(mc[k][0])}));
        chk({p, "_vote"}, 32'(vt), 32'(mv[k]));
        if (fin === 1'b1 && prev_fin[k] !== 1'b1) begin
            have = (k == 0) ? (q5.size() > 0) : (q4.size() > 0);
            n_checks++;
            if (!have) begin
                n_fail++;
                $display("FAIL %s_unexpected_finished actual=1 required=0 at %0t", p, $time);
            end else begin
                r = (k == 0) ? q5.pop_front() : q4.pop_front();
                chk({p, "_sb_count0"}, 32'(oc[2:0]), 32'(r.c0));
                chk({p, "_sb_count1"}, 32'(oc[5:3]), 32'(r.c1));
                chk({p, "_sb_vote"}, 32'(vt), 32'(r.vt));
`ifdef PMVC_STABILITY_FLAG_EN
                chk({p, "_sb_unstable"}, 32'(un), 32'(r.un));
`endif
            end
        end
        prev_fin[k] = fin;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, busy5, fin5, tc5, oc5, vote5, un5);
            mon(1, busy4, fin4, tc4, oc4, vote4, un4);
        end
    end

    task automatic step(input logic rs, input logic st, input logic en, input logic sv,
                        input logic [1:0] rp, input logic ak);
        reset = rs; start = st; enable = en; sample_valid = sv; response = rp; ack = ak;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic acc(input logic [1:0] rp);
        step(1'b1, 1'b0, 1'b1, 1'b1, rp, 1'b0);
    endtask

    task automatic go();
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic take();
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    endtask

    initial begin
        prev_fin[0] = 1'b0;
        prev_fin[1] = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1);
        mon_en = 1'b1;
        chk("reset_out_counter", 32'(oc5), 32'd0);
        chk("reset_vote", 32'(vote5), 32'd0);

        // reset in the middle of a measurement
        go();
        repeat (3) acc(2'b11);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0);
        chk("midreset_busy", 32'(busy5), 32'd0);
        chk("midreset_trial_count", 32'(tc5), 32'd0);
        chk("midreset_out_counter", 32'(oc5), 32'd0);
        go();
        repeat (4) acc(2'($urandom));
        chk("midreset_not_done_at_4", 32'(fin5), 32'd0);
        acc(2'($urandom));
        chk("midreset_done_at_5", 32'(fin5), 32'd1);
        take();

        // basic vote: ch0 = 1,1,1,0,0  ch1 = 0,0,1,0,0
        go();
        acc(2'b01); acc(2'b01); acc(2'b11); acc(2'b00); acc(2'b00);
        chk("basic_finished", 32'(fin5), 32'd1);
        chk("basic_counts", 32'(oc5), 32'({3'd1, 3'd3}));
        chk("basic_vote", 32'(vote5), 32'b01);
        chk("basic_trial_count", 32'(tc5), 32'd5);
        take();

        // tie on the TRIALS=4 instance: ch0 two ones, ch1 three ones
        go();
        acc(2'b11); acc(2'b11); acc(2'b10); acc(2'b00);
        chk("tie_vote", 32'(vote4), 32'b10);
        chk("tie_counts", 32'(oc4), 32'({3'd3, 3'd2}));
        acc(2'b00);
        take();

        // paused and unqualified cycles carry response=11 and must add nothing
        go();
        acc(2'b01);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        acc(2'b10);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
        acc(2'b01);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        acc(2'b00);
        chk("pause_not_done", 32'(fin5), 32'd0);
        acc(2'b11);
        chk("pause_counts", 32'(oc5), 32'({3'd2, 3'd3}));
        chk("pause_vote", 32'(vote5), 32'b01);

        // handshake: ack holds results; start during COUNT ignored; start beats ack
        take();
        chk("ack_finished_low", 32'(fin5), 32'd0);
        chk("ack_counts_held", 32'(oc5), 32'({3'd2, 3'd3}));
        go();
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0);
        chk("start_in_count_ignored", 32'(tc5), 32'd1);
        repeat (4) acc(2'b10);
        chk("hs_done", 32'(fin5), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        chk("start_ack_busy", 32'(busy5), 32'd1);
        chk("start_ack_cleared", 32'(oc5), 32'd0);
        repeat (5) acc(2'($urandom));
        take();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 75),
                 2'($urandom), ($urandom_range(0, 99) < 15));
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        chk("scoreboard_drained_t5", 32'(q5.size()), 32'd0);
        chk("scoreboard_drained_t4", 32'(q4.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
